// File: rtl/matrix_deconstruct_pkg.sv
// Shared state encoding, default sizes and flat-slot index helper for the
// matrix read-out path.
package matrix_deconstruct_pkg;

  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_MAX_DIM = 128;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_e;

  // LSB of entry (row,col) in the flat bus; kept at 32 bits so large
  // MAX_DIM*DW products never truncate.
  function automatic logic [31:0] slot_lsb(input logic [7:0] row,
                                           input logic [7:0] col,
                                           input int unsigned max_dim,
                                           input int unsigned dw);
    return ((32'(row) * max_dim) + 32'(col)) * dw;
  endfunction

endpackage

// File: rtl/matrix_deconstruct_addr_walk.sv
// Row-major (row,col) walker: start loads (0,0) and the bounds, advance steps
// the column first and wraps into the next row; last flags (m-1,n-1).
module matrix_addr_walk
  import matrix_deconstruct_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       advance_i,
  input  logic [7:0] m_dim_i,
  input  logic [7:0] n_dim_i,
  output logic [7:0] row_o,
  output logic [7:0] col_o,
  output logic       last_o
);

  logic [7:0] row_q, row_d;
  logic [7:0] col_q, col_d;
  logic [7:0] m_q, m_d;
  logic [7:0] n_q, n_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    m_d   = m_q;
    n_d   = n_q;
    if (start_i) begin
      row_d = '0;
      col_d = '0;
      m_d   = m_dim_i;
      n_d   = n_dim_i;
    end else if (advance_i) begin
      if (col_q == n_q - 8'd1) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
      m_q   <= '0;
      n_q   <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      m_q   <= m_d;
      n_q   <= n_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == m_q - 8'd1) && (col_q == n_q - 8'd1);

endmodule

// File: rtl/matrix_deconstruct.sv
// Walks an m x n matrix out of mn_matrix storage one read per cycle and packs
// the returned entries into a flat MAX_DIM-strided bus, optionally transposed.
module matrix_deconstruct
  import matrix_deconstruct_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned MAX_DIM = DEF_MAX_DIM,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    m_dim,
  input  logic [7:0]                    n_dim,
  input  logic                          transpose,
  output logic                          rd_en,
  output logic [7:0]                    rd_m_addr,
  output logic [7:0]                    rd_n_addr,
  input  logic [DW-1:0]                 rd_data,
  output logic [MAX_DIM*MAX_DIM*DW-1:0] matrix_out,
  output logic                          busy,
  output logic                          done,
  output logic                          dim_err
);

  localparam logic [7:0]         MAX_DIM_B = 8'(MAX_DIM);
  localparam int unsigned        PW        = RD_LAT * 8;
  localparam logic [RD_LAT-1:0]  UP_MASK   = {RD_LAT{1'b1}} >> 1;

  state_e state_q, state_d;
  logic   rd_en_q, rd_en_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   dim_err_q, dim_err_d;
  logic   transp_q, transp_d;

  logic [MAX_DIM*MAX_DIM*DW-1:0] matrix_q;
  logic [RD_LAT-1:0]             vld_q;
  logic [RD_LAT-1:0][7:0]        row_pipe_q;
  logic [RD_LAT-1:0][7:0]        col_pipe_q;

  logic       accept;
  logic       walk_last;
  logic       upstream_pending;
  logic [7:0] walk_row, walk_col;

  assign accept = start && (state_q == IDLE);

  matrix_addr_walk u_walk (
    .clk       (clk),
    .reset     (reset),
    .start_i   (accept),
    .advance_i (rd_en_q && !walk_last),
    .m_dim_i   (m_dim),
    .n_dim_i   (n_dim),
    .row_o     (walk_row),
    .col_o     (walk_col),
    .last_o    (walk_last)
  );

  // Reads still in flight ahead of the output stage; once clear, the stage
  // being captured this cycle (if any) is the final one.
  assign upstream_pending = |(vld_q & UP_MASK);

  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dim_err_d = dim_err_q;
    transp_d  = transp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          dim_err_d = 1'b0;
          transp_d  = transpose;
          // Empty or oversized walks pass through DRAIN with an empty pipe so
          // done lands one cycle later, same as any walk with nothing in flight.
          if (m_dim == 8'd0 || n_dim == 8'd0) begin
            state_d = DRAIN;
          end else if (m_dim > MAX_DIM_B || n_dim > MAX_DIM_B) begin
            dim_err_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            rd_en_d = 1'b1;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (walk_last) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!upstream_pending) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dim_err_q  <= 1'b0;
      transp_q   <= 1'b0;
      matrix_q   <= '0;
      vld_q      <= '0;
      row_pipe_q <= '0;
      col_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dim_err_q  <= dim_err_d;
      transp_q   <= transp_d;
      vld_q      <= RD_LAT'({vld_q, rd_en_q});
      row_pipe_q <= PW'({row_pipe_q, (transp_q ? walk_col : walk_row)});
      col_pipe_q <= PW'({col_pipe_q, (transp_q ? walk_row : walk_col)});
      if (accept) begin
        matrix_q <= '0;
      end else if (vld_q[RD_LAT-1]) begin
        matrix_q[slot_lsb(row_pipe_q[RD_LAT-1], col_pipe_q[RD_LAT-1], MAX_DIM, DW) +: DW] <= rd_data;
      end
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_m_addr  = walk_row;
  assign rd_n_addr  = walk_col;
  assign matrix_out = matrix_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dim_err    = dim_err_q;

endmodule

// File: tb/tb_matrix_deconstruct.sv
// Scoreboard bench: stimulus pushes the expected packed matrix and timing for
// every accepted start; a negedge monitor pops and compares on each done.
module tb_matrix_deconstruct;

  localparam int DW = 16;
  localparam int MD = 16;
  localparam int L  = 3;
  localparam int FW = MD * MD * DW;

  typedef struct {
    logic [FW-1:0] mat;
    logic          err;
    int            start_cyc;
    int            done_rel;
    int            reads;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    m_dim = 8'd0;
  logic [7:0]    n_dim = 8'd0;
  logic          transpose = 1'b0;
  logic          rd_en;
  logic [7:0]    rd_m_addr, rd_n_addr;
  logic [DW-1:0] rd_data;
  logic [FW-1:0] matrix_out;
  logic          busy, done, dim_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   txn = 0;
  int   rd_cnt = 0, rd_first = 0, rd_last = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [DW-1:0] mem [MD][MD];
  logic [DW-1:0] rsp [L];

  matrix_deconstruct #(.DW(DW), .MAX_DIM(MD), .RD_LAT(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .m_dim      (m_dim),
    .n_dim      (n_dim),
    .transpose  (transpose),
    .rd_en      (rd_en),
    .rd_m_addr  (rd_m_addr),
    .rd_n_addr  (rd_n_addr),
    .rd_data    (rd_data),
    .matrix_out (matrix_out),
    .busy       (busy),
    .done       (done),
    .dim_err    (dim_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Storage model: data for a read issued in cycle k is presented in cycle k+L.
  always @(posedge clk) begin
    rsp[0] <= rd_en ? mem[rd_m_addr[3:0]][rd_n_addr[3:0]] : '0;
    for (int s = 1; s < L; s++) rsp[s] <= rsp[s-1];
  end
  assign rd_data = rsp[L-1];

  task automatic cmp(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      rd_cnt = 0;
    end else begin
      if (rd_en) begin
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        rd_cnt++;
        cmp("busy_during_read", busy, 1);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got done=1 want none (cyc %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          cmp("done_cycle", cyc - mon_e.start_cyc, mon_e.done_rel);
          cmp("dim_err", dim_err, mon_e.err);
          cmp("busy_at_done", busy, 0);
          cmp("read_count", rd_cnt, mon_e.reads);
          if (mon_e.reads > 0) begin
            cmp("first_read_cycle", rd_first - mon_e.start_cyc, 1);
            cmp("read_no_bubble", rd_last - rd_first + 1, mon_e.reads);
          end
          checks++;
          if (matrix_out !== mon_e.mat) begin
            errors++;
            for (int s = 0; s < MD * MD; s++) begin
              if (matrix_out[s*DW +: DW] !== mon_e.mat[s*DW +: DW]) begin
                $display("FAIL matrix_out slot(%0d,%0d) got %h want %h", s / MD, s % MD,
                         matrix_out[s*DW +: DW], mon_e.mat[s*DW +: DW]);
                break;
              end
            end
          end
          $display("txn %0d: done at rel cycle %0d reads %0d dim_err %0d", txn,
                   cyc - mon_e.start_cyc, rd_cnt, dim_err);
          txn++;
        end
        rd_cnt = 0;
      end
    end
  end

  // Call at a negedge; leaves the bench at the negedge after start is sampled.
  task automatic issue(input int m, input int n, input bit tr, input bit ramp);
    exp_t e;
    bit   zero, err;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++)
        mem[i][j] = ramp ? DW'(16 + i * n + j) : DW'($urandom);
    zero = (m == 0) || (n == 0);
    err  = !zero && (m > MD || n > MD);
    e.mat = '0;
    if (!zero && !err) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++) begin
          if (tr) e.mat[(j * MD + i) * DW +: DW] = mem[i][j];
          else    e.mat[(i * MD + j) * DW +: DW] = mem[i][j];
        end
    end
    e.err       = err;
    e.reads     = (zero || err) ? 0 : m * n;
    e.start_cyc = cyc;
    e.done_rel  = (zero || err) ? 2 : m * n + L + 1;
    exp_q.push_back(e);
    m_dim     = 8'(m);
    n_dim     = 8'(n);
    transpose = tr;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL wait_idle timeout got busy=%0d pending=%0d want idle", busy, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int m, n, k;
    repeat (3) @(negedge clk);
    cmp("rst_rd_en", rd_en, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_dim_err", dim_err, 0);
    cmp("rst_addr", {rd_m_addr, rd_n_addr}, 0);
    cmp("rst_matrix_nonzero", (matrix_out != '0), 0);
    reset = 1'b1;
    @(negedge clk);

    issue(2, 3, 1'b0, 1'b1); wait_idle(200);
    issue(2, 3, 1'b1, 1'b1); wait_idle(200);

    repeat (8) begin
      m = $urandom_range(1, MD);
      n = $urandom_range(1, MD);
      issue(m, n, 1'($urandom_range(0, 1)), 1'b0);
      wait_idle(MD * MD + 50);
    end
    issue(MD, MD, 1'b0, 1'b0); wait_idle(MD * MD + 50);
    issue(MD, MD, 1'b1, 1'b0); wait_idle(MD * MD + 50);
    issue(1, 1, 1'b0, 1'b0);   wait_idle(50);
    issue(1, MD, 1'b1, 1'b0);  wait_idle(100);
    issue(MD, 1, 1'b0, 1'b0);  wait_idle(100);

    issue(0, 5, 1'b0, 1'b0);   wait_idle(50);
    issue(200, 3, 1'b0, 1'b0); wait_idle(50);
    cmp("dim_err_sticky", dim_err, 1);
    issue(MD + 1, 2, 1'b0, 1'b0); wait_idle(50);
    issue(3, 0, 1'b0, 1'b0);   wait_idle(50);
    cmp("dim_err_cleared", dim_err, 0);

    // start re-pulsed mid-walk must not restart or add reads
    issue(4, 4, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100);

    // start held during the done/FIN cycle must be ignored
    issue(1, 1, 1'b0, 1'b0);
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    cmp("fin_reached", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    cmp("fin_start_ignored", busy, 0);
    wait_idle(50);

    // async reset mid-walk: outputs clear at once, no done afterwards
    issue(3, 4, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    cmp("abort_rd_en", rd_en, 0);
    cmp("abort_busy", busy, 0);
    cmp("abort_done", done, 0);
    cmp("abort_addr", {rd_m_addr, rd_n_addr}, 0);
    cmp("abort_matrix_nonzero", (matrix_out != '0), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    cmp("abort_no_done_busy", busy, 0);
    issue(2, 3, 1'b0, 1'b1); wait_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
